// File: rtl/ctr_keystream_xor.sv
// CTR-mode sequencing stage: builds iv+count, launches AES, XORs the keystream
// with the buffered plaintext and presents the ciphertext on a valid/ready port.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   iv_i, count_i, cnt_en_o  counter block inputs and block-counter increment pulse
//   pt_*                     plaintext valid/ready input (data, last)
//   aes_*                    AES core start/block out, done/keystream in
//   ct_*                     ciphertext valid/ready output (data, last)
//   busy_o, err_o            not-idle indicator, sticky AES-timeout flag
module ctr_keystream_xor #(
  parameter int unsigned AES_TIMEOUT = 64,
  parameter int unsigned TMO_W       = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [127:0] iv_i,
  input  logic [127:0] count_i,
  output logic         cnt_en_o,
  input  logic         pt_valid_i,
  output logic         pt_ready_o,
  input  logic [127:0] pt_data_i,
  input  logic         pt_last_i,
  output logic         aes_start_o,
  output logic [127:0] aes_block_o,
  input  logic         aes_done_i,
  input  logic [127:0] aes_data_i,
  output logic         ct_valid_o,
  input  logic         ct_ready_i,
  output logic [127:0] ct_data_o,
  output logic         ct_last_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic [127:0] pt_q, pt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] ct_q, ct_d;
  logic         last_q, last_d;
  logic         ct_last_q, ct_last_d;
  logic         err_q, err_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic         tmo;

  assign tmo = (wd_q == TMO_W'(AES_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    pt_d      = pt_q;
    last_d    = last_q;
    blk_d     = blk_q;
    ct_d      = ct_q;
    ct_last_d = ct_last_q;
    err_d     = err_q;
    wd_d      = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (pt_valid_i) begin
          pt_d    = pt_data_i;
          last_d  = pt_last_i;
          // carry out of bit 127 is intentionally dropped
          blk_d   = iv_i + count_i;
          state_d = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + 1'b1;
        // a done arriving on the last allowed cycle still wins
        if (aes_done_i) begin
          ct_d      = aes_data_i ^ pt_q;
          ct_last_d = last_q;
          state_d   = S_OUT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (ct_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pt_q      <= '0;
      last_q    <= 1'b0;
      blk_q     <= '0;
      ct_q      <= '0;
      ct_last_q <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      pt_q      <= pt_d;
      last_q    <= last_d;
      blk_q     <= blk_d;
      ct_q      <= ct_d;
      ct_last_q <= ct_last_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  // rst_ni gating keeps handshake and pulses quiet while reset is held
  assign pt_ready_o  = rst_ni & (state_q == S_IDLE);
  assign aes_start_o = rst_ni & (state_q == S_START);
  assign cnt_en_o    = rst_ni & (state_q == S_START);
  assign aes_block_o = blk_q;
  assign ct_valid_o  = (state_q == S_OUT);
  assign ct_data_o   = ct_q;
  assign ct_last_o   = ct_last_q;
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;

endmodule
